// File: rtl/mem_loader_pkg.sv
// Shared definitions for the host-link memory loader: command bytes, section size limit
// and the loader FSM state encoding.
package mem_loader_pkg;

  localparam logic [7:0] CmdInst = 8'h49;  // 'I'
  localparam logic [7:0] CmdData = 8'h44;  // 'D'
  localparam logic [7:0] CmdEnd  = 8'h45;  // 'E'

  localparam int unsigned MaxPairs = 64;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StCount,
    StData,
    StCommit,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-pair assembler: shifts little-endian bytes into a 64-bit word and flags the
// shift that completes the eighth byte.
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic        full_o
);

  logic [63:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = {byte_i, word_q[63:8]};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state word so the consumer can commit the full pair on the eighth byte's edge.
  assign word_o = word_d;
  assign full_o = shift_i && (cnt_q == 3'd7);

endmodule

// File: rtl/mem_loader.sv
// Host byte-stream loader: parses I/D/E commands and writes 64-bit pairs atomically
// into the instruction or data memory load ports of the pipeline.
module mem_loader
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        enable_load_ex_mem_o,
  output logic [8:0]  inst_addr_o,
  output logic [31:0] inst_data1_o,
  output logic [31:0] inst_data2_o,
  output logic [8:0]  data_addr_o,
  output logic [31:0] data_data1_o,
  output logic [31:0] data_data2_o,
  output logic        load_done_o,
  output logic        load_error_o,
  output logic [6:0]  pairs_loaded_o
);

  loader_state_e state_q;
  logic          rx_ready_q, enable_q, done_q, error_q, sel_inst_q;
  logic [6:0]    n_q, pairs_q;
  logic [8:0]    inst_addr_q, data_addr_q;
  logic [31:0]   inst_d1_q, inst_d2_q, data_d1_q, data_d2_q;

  logic        in_cmd, cmd_accept, asm_shift, asm_full, is_sect_cmd, bad_count;
  logic [63:0] asm_word;
  logic [8:0]  pair_addr;
  logic [6:0]  pairs_inc;

  assign in_cmd      = (state_q == StIdle) || (state_q == StCmd);
  assign cmd_accept  = in_cmd && rx_valid_i;
  assign asm_shift   = (state_q == StData) && rx_valid_i;
  assign is_sect_cmd = (rx_data_i == CmdInst) || (rx_data_i == CmdData);
  assign bad_count   = (rx_data_i == 8'd0) || (rx_data_i > 8'(MaxPairs));
  assign pair_addr   = {pairs_q[5:0], 3'b000};
  assign pairs_inc   = pairs_q + 7'd1;

  loader_word_asm u_word_asm (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cmd_accept),
    .shift_i (asm_shift),
    .byte_i  (rx_data_i),
    .word_o  (asm_word),
    .full_o  (asm_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_ready_q  <= 1'b1;
      enable_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sel_inst_q  <= 1'b0;
      n_q         <= '0;
      pairs_q     <= '0;
      inst_addr_q <= '0;
      inst_d1_q   <= '0;
      inst_d2_q   <= '0;
      data_addr_q <= '0;
      data_d1_q   <= '0;
      data_d2_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StCmd: begin
          if (rx_valid_i) begin
            if (is_sect_cmd) begin
              state_q    <= StCount;
              sel_inst_q <= (rx_data_i == CmdInst);
              enable_q   <= 1'b1;
              pairs_q    <= '0;
            end else if (rx_data_i == CmdEnd) begin
              state_q    <= StDone;
              rx_ready_q <= 1'b0;
              enable_q   <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= StError;
              rx_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end
          end
        end
        StCount: begin
          if (rx_valid_i) begin
            n_q <= rx_data_i[6:0];
            if (bad_count) begin
              state_q    <= StError;
              rx_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (asm_full) begin
            state_q    <= StCommit;
            rx_ready_q <= 1'b0;
            if (sel_inst_q) begin
              inst_addr_q <= pair_addr;
              inst_d1_q   <= asm_word[31:0];
              inst_d2_q   <= asm_word[63:32];
            end else begin
              data_addr_q <= pair_addr;
              data_d1_q   <= asm_word[31:0];
              data_d2_q   <= asm_word[63:32];
            end
          end
        end
        StCommit: begin
          pairs_q    <= pairs_inc;
          rx_ready_q <= 1'b1;
          state_q    <= (pairs_inc < n_q) ? StData : StCmd;
        end
        StDone, StError: state_q <= state_q;
        default: begin
          state_q    <= StError;
          rx_ready_q <= 1'b0;
          error_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready_o           = rx_ready_q;
  assign enable_load_ex_mem_o = enable_q;
  assign inst_addr_o          = inst_addr_q;
  assign inst_data1_o         = inst_d1_q;
  assign inst_data2_o         = inst_d2_q;
  assign data_addr_o          = data_addr_q;
  assign data_data1_o         = data_d1_q;
  assign data_data2_o         = data_d2_q;
  assign load_done_o          = done_q;
  assign load_error_o         = error_q;
  assign pairs_loaded_o       = pairs_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a transaction-level model predicts every committed pair
// and the final loader status.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, enable_load, load_done, load_error;
  logic [8:0]  inst_addr, data_addr;
  logic [31:0] inst_data1, inst_data2, data_data1, data_data2;
  logic [6:0]  pairs_loaded;

  always #5 clk = ~clk;

  mem_loader u_dut (
    .clk                  (clk),
    .reset                (reset),
    .rx_valid_i           (rx_valid),
    .rx_data_i            (rx_data),
    .rx_ready_o           (rx_ready),
    .enable_load_ex_mem_o (enable_load),
    .inst_addr_o          (inst_addr),
    .inst_data1_o         (inst_data1),
    .inst_data2_o         (inst_data2),
    .data_addr_o          (data_addr),
    .data_data1_o         (data_data1),
    .data_data2_o         (data_data2),
    .load_done_o          (load_done),
    .load_error_o         (load_error),
    .pairs_loaded_o       (pairs_loaded)
  );

  typedef struct {
    bit          inst;
    logic [8:0]  addr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [6:0]  k;
  } pair_t;

  pair_t       exp_q[$];
  logic [8:0]  m_iaddr, m_daddr;
  logic [31:0] m_id1, m_id2, m_dd1, m_dd2;
  int          tests = 0;
  int          fails = 0;
  int          commits = 0;
  bit          mon_on = 0;
  bit          prev_commit = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_iaddr = '0; m_id1 = '0; m_id2 = '0;
    m_daddr = '0; m_dd1 = '0; m_dd2 = '0;
    prev_commit = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b0;
  endtask

  // Entered and left on a falling edge; the handshake lands on the rising edge between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pair(input bit inst, input int k, input logic [63:0] pair, input int gap);
    pair_t p;
    p.inst = inst;
    p.addr = 9'(8 * k);
    p.d1   = pair[31:0];
    p.d2   = pair[63:32];
    p.k    = 7'(k);
    exp_q.push_back(p);
    for (int i = 0; i < 8; i++) send_byte(pair[8*i +: 8], $urandom_range(0, gap));
  endtask

  task automatic load_section(input bit inst, input int n, input int gap);
    send_byte(inst ? 8'h49 : 8'h44, $urandom_range(0, gap));
    send_byte(8'(n), $urandom_range(0, gap));
    for (int k = 0; k < n; k++) send_pair(inst, k, {$urandom(), $urandom()}, gap);
  endtask

  task automatic check_mem_hold(input string tag);
    check({tag, "_iaddr"}, 64'(inst_addr), 64'(m_iaddr));
    check({tag, "_idata"}, {inst_data2, inst_data1}, {m_id2, m_id1});
    check({tag, "_daddr"}, 64'(data_addr), 64'(m_daddr));
    check({tag, "_ddata"}, {data_data2, data_data1}, {m_dd2, m_dd1});
  endtask

  task automatic settle_and_drain(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_pending_commits"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Commit monitor: a cycle with rx_ready low outside DONE/ERROR is a COMMIT cycle.
  initial begin
    pair_t p;
    bit    commit;
    forever begin
      @(negedge clk);
      if (mon_on && !reset) begin
        commit = !rx_ready && !load_done && !load_error;
        if (commit) begin
          commits++;
          check("commit_one_cycle", 64'(prev_commit), 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_commit", 64'd1, 64'd0);
          end else begin
            p = exp_q.pop_front();
            if (p.inst) begin
              m_iaddr = p.addr; m_id1 = p.d1; m_id2 = p.d2;
            end else begin
              m_daddr = p.addr; m_dd1 = p.d1; m_dd2 = p.d2;
            end
            check_mem_hold("commit");
            check("commit_pairs_loaded", 64'(pairs_loaded), 64'(p.k));
          end
        end
        prev_commit = commit;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    do_reset();
    mon_on = 1;

    // Reset state
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_enable", 64'(enable_load), 64'd0);
    check("rst_flags", {62'd0, load_done, load_error}, 64'd0);
    check("rst_pairs", 64'(pairs_loaded), 64'd0);
    check_mem_hold("rst");

    // 'I',1 with bytes 01..08
    send_byte(8'h49, 0);
    send_byte(8'h01, 0);
    send_pair(1'b1, 0, 64'h0807060504030201, 0);
    settle_and_drain("i1");
    check("i1_addr", 64'(inst_addr), 64'd0);
    check("i1_data1", 64'(inst_data1), 64'h04030201);
    check("i1_data2", 64'(inst_data2), 64'h08070605);
    check("i1_pairs", 64'(pairs_loaded), 64'd1);
    check("i1_enable", 64'(enable_load), 64'd1);

    // 'D',2 then 'E'
    load_section(1'b0, 2, 2);
    settle_and_drain("d2");
    check("d2_daddr", 64'(data_addr), 64'd8);
    check("d2_iaddr", 64'(inst_data1), 64'h04030201);
    send_byte(8'h45, 1);
    repeat (3) @(negedge clk);
    check("end_enable", 64'(enable_load), 64'd0);
    check("end_done", 64'(load_done), 64'd1);
    check("end_ready", 64'(rx_ready), 64'd0);
    check_mem_hold("end_hold");

    // 'I',0 -> ERROR, absorbing
    do_reset();
    send_byte(8'h49, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 100; i++) begin
      check("n0_status", {61'd0, load_error, rx_ready, enable_load}, {61'd0, 3'b101});
      @(negedge clk);
    end

    // 'I',65 -> ERROR
    do_reset();
    send_byte(8'h49, 1);
    send_byte(8'd65, 1);
    @(negedge clk);
    check("n65_status", {61'd0, load_error, rx_ready, enable_load}, {61'd0, 3'b101});

    // Unknown command from IDLE -> ERROR without entering load mode
    do_reset();
    send_byte(8'h55, 0);
    @(negedge clk);
    check("bad_cmd_status", {61'd0, load_error, rx_ready, enable_load}, {61'd0, 3'b100});

    // 'E' from IDLE leaves load mode off
    do_reset();
    send_byte(8'h45, 0);
    @(negedge clk);
    check("e_idle_status", {61'd0, load_done, rx_ready, enable_load}, {61'd0, 3'b100});

    // 'I',64 with random valid gaps
    do_reset();
    c0 = commits;
    load_section(1'b1, 64, 3);
    settle_and_drain("i64");
    check("i64_commits", 64'(commits - c0), 64'd64);
    check("i64_last_addr", 64'(inst_addr), 64'd504);
    check("i64_pairs", 64'(pairs_loaded), 64'd64);

    // Random mix of sections, then 'E'
    do_reset();
    for (int s = 0; s < 5; s++) load_section(1'($urandom_range(0, 1)), $urandom_range(1, 6), 2);
    settle_and_drain("mix");
    send_byte(8'h45, 0);
    repeat (2) @(negedge clk);
    check("mix_done", {62'd0, load_done, enable_load}, 64'b10);
    check_mem_hold("mix_hold");

    // Reset after byte 5 of a pair, then a clean 'I',1
    do_reset();
    send_byte(8'h49, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 0);
    do_reset();
    check("midrst_ready", 64'(rx_ready), 64'd1);
    check("midrst_status", {61'd0, load_done, load_error, enable_load}, 64'd0);
    check_mem_hold("midrst");
    load_section(1'b1, 1, 1);
    settle_and_drain("after_rst");
    check("after_rst_pairs", 64'(pairs_loaded), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
